alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : round-robin front end sharing one combinational ALU between
//               two requesters (IDLE -> EXEC -> RESP per operation).
// Option      : define ALU_ARB_FLAGS_EN to register and return the ALU flags.
// Revision    : 1.0
// ============================================================================
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*N-1:0] req_a,
  input  logic [2*N-1:0] req_b,
  input  logic [7:0]     req_ctrl,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [3:0]     alu_ctrl,
  input  logic [N-1:0]   alu_result,
  input  logic [3:0]     alu_flags,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [N-1:0]   rsp_result,
  output logic [3:0]     rsp_flags
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_exec = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic         r_last;
  logic         w_grant_any;
  logic         w_grant_id;
  logic         w_accept;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [3:0]   r_ctrl;
  logic         r_id;
  logic [N-1:0] r_result;

  // With both requesting, the one not served last wins.
  assign w_grant_any = |req_valid;
  assign w_grant_id  = (req_valid == 2'b11) ? ~r_last : req_valid[1];
  assign w_accept    = (r_state == c_st_idle) && w_grant_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_grant_any) w_state_nxt = c_st_exec;
      c_st_exec: w_state_nxt = c_st_resp;
      c_st_resp: if (rsp_ready) w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // req_ready is the only input-dependent output, so it is gated by reset too.
  always_comb begin
    req_ready = 2'b00;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = 4'b0000;
    rsp_valid = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (rst_n && w_grant_any) req_ready = 2'b01 << w_grant_id;
      end
      c_st_exec: begin
        alu_a    = r_a;
        alu_b    = r_b;
        alu_ctrl = r_ctrl;
      end
      c_st_resp: rsp_valid = 1'b1;
      default:   rsp_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_ctrl <= 4'b0000;
      r_id   <= 1'b0;
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_a    <= w_grant_id ? req_a[2*N-1:N] : req_a[N-1:0];
      r_b    <= w_grant_id ? req_b[2*N-1:N] : req_b[N-1:0];
      r_ctrl <= w_grant_id ? req_ctrl[7:4]  : req_ctrl[3:0];
      r_id   <= w_grant_id;
      r_last <= w_grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
    end else if (r_state == c_st_exec) begin
      r_result <= alu_result;
    end
  end

  assign rsp_id     = r_id;
  assign rsp_result = r_result;

`ifdef ALU_ARB_FLAGS_EN
  logic [3:0] r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if (r_state == c_st_exec) begin
      r_flags <= alu_flags;
    end
  end

  assign rsp_flags = r_flags;
`else
  logic w_unused_flags;

  assign w_unused_flags = ^alu_flags;
  assign rsp_flags      = 4'b0000;
`endif

endmodule
`default_nettype wire
